// File: rtl/mem_req_pkg.sv
// Shared defaults and types for the mem_req_ctrl request front-end.
package mem_req_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RBURST = 1'b1
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [LEN_W_DEF-1:0]  len;
  } req_t;

endpackage

// File: rtl/mem_req_rsp_fifo.sv
// Response FIFO holding {last, data} per read beat; exports its occupancy
// so the controller can derive request credits.
module mem_req_rsp_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + 1'b1;
    if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the read side is qualified by the count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Credit-flow-controlled request front-end for the single-port memory.
// Define MEM_REQ_BURST_EN to add req_len_i and incrementing read bursts.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = 4,
  parameter int READ_LAT  = 1
`ifdef MEM_REQ_BURST_EN
  ,
  parameter int LEN_W     = LEN_W_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
`ifdef MEM_REQ_BURST_EN
  input  logic [LEN_W-1:0]  req_len_i,
`endif
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_last_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic              accept;
  logic              idleState;
  logic              burstActive;
  logic [CNT_W-1:0]  fifoCount;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  credits;
  logic              fifoPush;
  logic              fifoPop;
  logic [DATA_W:0]   fifoRd;

  logic              readyEn_q;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic              memWe_q, memWe_d;
  logic              issueRd_q, issueRd_d;
  logic              issueLast_q, issueLast_d;
  logic [READ_LAT-1:0] tagValid_q;
  logic [READ_LAT-1:0] tagLast_q;

`ifdef MEM_REQ_BURST_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] burstAddr_q, burstAddr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;

  assign idleState   = (state_q == IDLE);
  assign burstActive = (state_q == RBURST);
`else
  assign idleState   = 1'b1;
  assign burstActive = 1'b0;
`endif

  // Every issued read holds a credit until its beat leaves the FIFO.
  always_comb begin
    inflight = CNT_W'(issueRd_q);
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(tagValid_q[i]);
    end
  end

  assign credits     = CNT_W'(RSP_DEPTH) - fifoCount - inflight;
  assign req_ready_o = readyEn_q && idleState && (credits != '0);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    memWe_d     = 1'b0;
    issueRd_d   = 1'b0;
    issueLast_d = 1'b1;
`ifdef MEM_REQ_BURST_EN
    state_d     = state_q;
    burstAddr_d = burstAddr_q;
    remain_d    = remain_q;
`endif
    if (accept) begin
      memAddr_d = req_addr_i;
      if (req_we_i) begin
        memWe_d    = 1'b1;
        memWdata_d = req_wdata_i;
      end else begin
        issueRd_d = 1'b1;
`ifdef MEM_REQ_BURST_EN
        issueLast_d = (req_len_i == '0);
        if (req_len_i != '0) begin
          state_d     = RBURST;
          burstAddr_d = req_addr_i + 1'b1;
          remain_d    = req_len_i;
        end
`endif
      end
    end
`ifdef MEM_REQ_BURST_EN
    // Remaining beats issue only while a FIFO slot is guaranteed.
    else if (state_q == RBURST && credits != '0) begin
      issueRd_d   = 1'b1;
      memAddr_d   = burstAddr_q;
      burstAddr_d = burstAddr_q + 1'b1;
      remain_d    = remain_q - 1'b1;
      issueLast_d = (remain_q == LEN_W'(1));
      if (remain_q == LEN_W'(1)) state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      readyEn_q   <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memWe_q     <= 1'b0;
      issueRd_q   <= 1'b0;
      issueLast_q <= 1'b0;
      tagValid_q  <= '0;
      tagLast_q   <= '0;
`ifdef MEM_REQ_BURST_EN
      state_q     <= IDLE;
      burstAddr_q <= '0;
      remain_q    <= '0;
`endif
    end else begin
      readyEn_q     <= 1'b1;
      memAddr_q     <= memAddr_d;
      memWdata_q    <= memWdata_d;
      memWe_q       <= memWe_d;
      issueRd_q     <= issueRd_d;
      issueLast_q   <= issueLast_d;
      tagValid_q[0] <= issueRd_q;
      tagLast_q[0]  <= issueLast_q;
      for (int i = 1; i < READ_LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagLast_q[i]  <= tagLast_q[i-1];
      end
`ifdef MEM_REQ_BURST_EN
      state_q     <= state_d;
      burstAddr_q <= burstAddr_d;
      remain_q    <= remain_d;
`endif
    end
  end

  assign fifoPush = tagValid_q[READ_LAT-1];
  assign fifoPop  = rsp_valid_o && rsp_ready_i;

  mem_req_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) uFifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (fifoPush),
    .wdata_i ({tagLast_q[READ_LAT-1], mem_rdata_i}),
    .pop_i   (fifoPop),
    .rdata_o (fifoRd),
    .count_o (fifoCount)
  );

  assign rsp_valid_o = (fifoCount != '0);
  assign rsp_rdata_o = rsp_valid_o ? fifoRd[DATA_W-1:0] : '0;

`ifdef MEM_REQ_BURST_EN
  assign rsp_last_o = rsp_valid_o & fifoRd[DATA_W];
`else
  logic unusedLast;
  assign unusedLast = fifoRd[DATA_W];
  assign rsp_last_o = 1'b1;
`endif

  assign mem_addr_o  = memAddr_q;
  assign mem_we_o    = memWe_q;
  assign mem_wdata_o = memWdata_q;
  assign busy_o      = (inflight != '0) || rsp_valid_o || burstActive;

endmodule
